// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the RAM port arbiter: read pipeline depth,
// index-width helper and the per-entry control flags of the read return path.
package ram_arb_pkg;

  localparam int RD_LAT = 2;

  // Index width for n requesters, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    for (int w = 1; w < 31; w++) begin
      if ((1 << w) >= n) return w;
    end
    return 31;
  endfunction

  typedef struct packed {
    logic valid;
    logic err;
    logic fwd;
  } rd_ctl_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Client/RAM-facing bundle of the RAM port arbiter.
// Handshake: req[i] is a valid that stays high until gnt[i]; gnt is the
// same-cycle accept, and a command transfers on every cycle where both are high.
interface ram_port_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 10,
  parameter int ADDR_W = 3,
  parameter int ID_W   = 1
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        gnt;
  logic                    rd_valid;
  logic [ID_W-1:0]         rd_id;
  logic [DATA_W-1:0]       rd_data;
  logic                    addr_err;
  logic                    ram_write;
  logic                    ram_read;
  logic [ADDR_W-1:0]       ram_addr_w;
  logic [ADDR_W-1:0]       ram_addr_r;
  logic [DATA_W-1:0]       ram_datain;
  logic [DATA_W-1:0]       ram_dataout;

  modport master (
    output req, req_we, req_addr, req_wdata, ram_dataout,
    input  gnt, rd_valid, rd_id, rd_data, addr_err,
    input  ram_write, ram_read, ram_addr_w, ram_addr_r, ram_datain
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, ram_dataout,
    output gnt, rd_valid, rd_id, rd_data, addr_err,
    output ram_write, ram_read, ram_addr_w, ram_addr_r, ram_datain
  );
endinterface

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from its pointer with wrap-around, grants one
// requester combinationally, and moves the pointer just past the winner.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     i_req,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_vld
);

  logic [IDX_W-1:0] r_ptr;

  always_comb begin
    int               j;
    logic [IDX_W-1:0] w_idx;
    j         = 0;
    w_idx     = '0;
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N) j = j - N;
      w_idx = IDX_W'(j);
      if (!o_gnt_vld && i_req[w_idx]) begin
        o_gnt_vld = 1'b1;
        o_gnt_idx = w_idx;
      end
    end
    if (o_gnt_vld) o_gnt[o_gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (o_gnt_vld) begin
      r_ptr <= (int'(o_gnt_idx) == N - 1) ? '0 : o_gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM write port and one read port among N_REQ requesters with
// independent round-robin arbiters. Optional macro RAM_ARB_RAW_BYPASS_EN
// forwards same-cycle write data to a read of the same address.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int MEM_SIZE = 6,
  parameter int DATA_W   = 10,
  parameter int ADDR_W   = 3,
  parameter int ID_W     = 1
) (
  input logic                clk,
  input logic                rst_n,
  ram_port_arbiter_if.slave  bus
);

  localparam int IDX_W = clog2_min1(N_REQ);

  typedef struct packed {
    rd_ctl_t           ctl;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } rd_ent_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(MEM_SIZE));
  endfunction

  logic [N_REQ-1:0]  w_wr_req, w_rd_req, w_wr_gnt, w_rd_gnt;
  logic [IDX_W-1:0]  w_wr_idx, w_rd_idx;
  logic              w_wr_vld, w_rd_vld;
  logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;
  logic [DATA_W-1:0] w_wr_data, w_rd_data;
  logic              w_wr_err, w_rd_err, w_wr_ok, w_rd_ok, w_fwd;
  rd_ent_t           w_new, w_last;

  logic              r_ram_write, r_ram_read, r_addr_err;
  logic [ADDR_W-1:0] r_addr_w, r_addr_r;
  logic [DATA_W-1:0] r_datain;
  rd_ent_t           r_pipe [RD_LAT];

  assign w_wr_req = bus.req & bus.req_we;
  assign w_rd_req = bus.req & ~bus.req_we;

  rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_wr_arb (
    .clk(clk), .rst_n(rst_n), .i_req(w_wr_req),
    .o_gnt(w_wr_gnt), .o_gnt_idx(w_wr_idx), .o_gnt_vld(w_wr_vld)
  );

  rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rd_arb (
    .clk(clk), .rst_n(rst_n), .i_req(w_rd_req),
    .o_gnt(w_rd_gnt), .o_gnt_idx(w_rd_idx), .o_gnt_vld(w_rd_vld)
  );

  assign w_wr_addr = bus.req_addr[int'(w_wr_idx)*ADDR_W +: ADDR_W];
  assign w_wr_data = bus.req_wdata[int'(w_wr_idx)*DATA_W +: DATA_W];
  assign w_rd_addr = bus.req_addr[int'(w_rd_idx)*ADDR_W +: ADDR_W];

  // Out-of-range requests are still granted so the client never stalls.
  assign w_wr_err = w_wr_vld && !in_range(w_wr_addr);
  assign w_rd_err = w_rd_vld && !in_range(w_rd_addr);
  assign w_wr_ok  = w_wr_vld && !w_wr_err;
  assign w_rd_ok  = w_rd_vld && !w_rd_err;

`ifdef RAM_ARB_RAW_BYPASS_EN
  assign w_fwd = w_wr_ok && w_rd_ok && (w_wr_addr == w_rd_addr);
`else
  assign w_fwd = 1'b0;
`endif

  always_comb begin
    w_new = '0;
    if (w_rd_vld) begin
      w_new.ctl.valid = 1'b1;
      w_new.ctl.err   = w_rd_err;
      w_new.ctl.fwd   = w_fwd;
      w_new.id        = ID_W'(w_rd_idx);
      w_new.data      = w_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_write <= 1'b0;
      r_ram_read  <= 1'b0;
      r_addr_err  <= 1'b0;
      r_addr_w    <= '0;
      r_addr_r    <= '0;
      r_datain    <= '0;
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_ram_write <= w_wr_ok;
      r_ram_read  <= w_rd_ok;
      if (w_wr_err || w_rd_err) r_addr_err <= 1'b1;
      if (w_wr_ok) begin
        r_addr_w <= w_wr_addr;
        r_datain <= w_wr_data;
      end
      if (w_rd_ok) r_addr_r <= w_rd_addr;
      r_pipe[0] <= w_new;
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // RAM data arrives in the same cycle the last pipeline stage is presented.
  assign w_last = r_pipe[RD_LAT-1];

  always_comb begin
    w_rd_data = '0;
    if (w_last.ctl.valid && !w_last.ctl.err) begin
      w_rd_data = w_last.ctl.fwd ? w_last.data : bus.ram_dataout;
    end
  end

  assign bus.gnt        = rst_n ? (w_wr_gnt | w_rd_gnt) : '0;
  assign bus.rd_valid   = w_last.ctl.valid;
  assign bus.rd_id      = w_last.id;
  assign bus.rd_data    = w_rd_data;
  assign bus.addr_err   = r_addr_err;
  assign bus.ram_write  = r_ram_write;
  assign bus.ram_read   = r_ram_read;
  assign bus.ram_addr_w = r_addr_w;
  assign bus.ram_addr_r = r_addr_r;
  assign bus.ram_datain = r_datain;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed vector table, corner sequences and random
// traffic, all checked against a cycle-level reference model and a RAM model.
module tb_ram_port_arbiter;

  localparam int N_REQ    = 2;
  localparam int MEM_SIZE = 6;
  localparam int DATA_W   = 10;
  localparam int ADDR_W   = 3;
  localparam int ID_W     = 1;
  localparam int EXP_W    = 16 + ID_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

  ram_port_arbiter #(
    .N_REQ(N_REQ), .MEM_SIZE(MEM_SIZE), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // RAM outside the arbiter: registered read, read-before-write on collision.
  logic [DATA_W-1:0] tb_mem [MEM_SIZE] = '{default: '0};
  logic [DATA_W-1:0] tb_dout = '0;
  always @(posedge clk) begin
    if (bus.ram_write) tb_mem[int'(bus.ram_addr_w)] <= bus.ram_datain;
    if (bus.ram_read)  tb_dout <= tb_mem[int'(bus.ram_addr_r)];
  end
  assign bus.ram_dataout = tb_dout;

  // ---------------- reference model state ----------------
  int                n_tests = 0;
  int                n_fail  = 0;
  int                cyc     = 0;
  int                ref_wp, ref_rp;
  logic              ref_err;
  logic [DATA_W-1:0] ref_mem [MEM_SIZE];
  logic              exp_ram_w, exp_ram_r;
  logic [ADDR_W-1:0] exp_aw, exp_ar;
  logic [DATA_W-1:0] exp_dw;
  logic [EXP_W-1:0]  exp_q[$];
  logic              log_v    [0:2047];
  logic [ID_W-1:0]   log_id   [0:2047];
  logic [DATA_W-1:0] log_data [0:2047];

  typedef struct {
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  we;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] d0, d1;
    logic [N_REQ-1:0]  gnt;
  } vec_t;

  vec_t vt [17];
  int   vcyc [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_val);
    n_tests++;
    if (act !== req_val) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req_val);
    end
  endtask

  function automatic int pick(input logic [N_REQ-1:0] cand, input int ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (cand[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ref_wp = 0;
    ref_rp = 0;
    ref_err = 1'b0;
    exp_ram_w = 1'b0;
    exp_ram_r = 1'b0;
    exp_aw = '0;
    exp_ar = '0;
    exp_dw = '0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic do_reset(input logic [N_REQ-1:0] req, input logic [N_REQ-1:0] we);
    rst_n = 1'b0;
    bus.req = req;
    bus.req_we = we;
    #1;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_ram_write", bus.ram_write, 0);
    chk("rst_ram_read", bus.ram_read, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_id", bus.rd_id, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_addr_err", bus.addr_err, 0);
    chk("rst_addr_w", bus.ram_addr_w, 0);
    chk("rst_addr_r", bus.ram_addr_r, 0);
    chk("rst_datain", bus.ram_datain, 0);
    @(posedge clk);
    #1;
    chk("rst_gnt_hold", bus.gnt, 0);
    rst_n = 1'b1;
    bus.req = '0;
    cyc++;
    model_reset();
  endtask

  task automatic tick(input logic [N_REQ-1:0] req, input logic [N_REQ-1:0] we,
                      input logic [N_REQ*ADDR_W-1:0] addr, input logic [N_REQ*DATA_W-1:0] wdata,
                      output logic [N_REQ-1:0] gnt_seen);
    int                wi, ri;
    logic [ADDR_W-1:0] wa, ra;
    logic [DATA_W-1:0] wd, rdv;
    logic [N_REQ-1:0]  eg;
    logic [EXP_W-1:0]  e;
    bus.req = req;
    bus.req_we = we;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    #1;
    wi = pick(req & we, ref_wp);
    ri = pick(req & ~we, ref_rp);
    eg = '0;
    if (wi >= 0) eg[wi] = 1'b1;
    if (ri >= 0) eg[ri] = 1'b1;
    chk("gnt", bus.gnt, eg);
    gnt_seen = bus.gnt;
    chk("ram_write", bus.ram_write, exp_ram_w);
    chk("ram_read", bus.ram_read, exp_ram_r);
    chk("ram_addr_w", bus.ram_addr_w, exp_aw);
    chk("ram_datain", bus.ram_datain, exp_dw);
    chk("ram_addr_r", bus.ram_addr_r, exp_ar);
    chk("addr_err", bus.addr_err, ref_err);
    if (exp_q.size() > 0 && int'(exp_q[0][EXP_W-1 -: 16]) == cyc) begin
      e = exp_q.pop_front();
      chk("rd_valid", bus.rd_valid, 1);
      chk("rd_id", bus.rd_id, e[DATA_W +: ID_W]);
      chk("rd_data", bus.rd_data, e[DATA_W-1:0]);
    end else begin
      chk("rd_valid_idle", bus.rd_valid, 0);
    end
    log_v[cyc] = bus.rd_valid;
    log_id[cyc] = bus.rd_id;
    log_data[cyc] = bus.rd_data;

    exp_ram_w = 1'b0;
    exp_ram_r = 1'b0;
    wa = '0;
    wd = '0;
    if (wi >= 0) begin
      wa = addr[wi*ADDR_W +: ADDR_W];
      wd = wdata[wi*DATA_W +: DATA_W];
      if (int'(wa) < MEM_SIZE) begin
        exp_ram_w = 1'b1;
        exp_aw = wa;
        exp_dw = wd;
      end else ref_err = 1'b1;
      ref_wp = (wi + 1) % N_REQ;
    end
    if (ri >= 0) begin
      ra = addr[ri*ADDR_W +: ADDR_W];
      if (int'(ra) < MEM_SIZE) begin
        exp_ram_r = 1'b1;
        exp_ar = ra;
        rdv = ref_mem[int'(ra)];
`ifdef RAM_ARB_RAW_BYPASS_EN
        if (wi >= 0 && int'(wa) < MEM_SIZE && wa == ra) rdv = wd;
`endif
      end else begin
        ref_err = 1'b1;
        rdv = '0;
      end
      exp_q.push_back({16'(cyc + 2), ID_W'(ri), rdv});
      ref_rp = (ri + 1) % N_REQ;
    end
    if (wi >= 0 && int'(wa) < MEM_SIZE) ref_mem[int'(wa)] = wd;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N_REQ-1:0] g;
    logic [DATA_W-1:0] exp_raw;
    for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = '0;
    model_reset();
    bus.req = '0;
    bus.req_we = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;

    vt[0]  = '{2'b11, 2'b11, 3'd1, 3'd2, 10'h00A, 10'h00B, 2'b01};
    vt[1]  = '{2'b11, 2'b11, 3'd1, 3'd2, 10'h00A, 10'h00B, 2'b10};
    vt[2]  = '{2'b11, 2'b11, 3'd1, 3'd2, 10'h01A, 10'h01B, 2'b01};
    vt[3]  = '{2'b11, 2'b11, 3'd1, 3'd2, 10'h01A, 10'h01B, 2'b10};
    vt[4]  = '{2'b11, 2'b00, 3'd1, 3'd2, 10'h000, 10'h000, 2'b01};
    vt[5]  = '{2'b11, 2'b01, 3'd1, 3'd2, 10'h033, 10'h000, 2'b11};
    vt[6]  = '{2'b01, 2'b01, 3'd3, 3'd0, 10'h02A, 10'h000, 2'b01};
    vt[7]  = '{2'b10, 2'b00, 3'd0, 3'd3, 10'h000, 10'h000, 2'b10};
    vt[8]  = '{2'b00, 2'b00, 3'd0, 3'd0, 10'h000, 10'h000, 2'b00};
    vt[9]  = '{2'b00, 2'b00, 3'd0, 3'd0, 10'h000, 10'h000, 2'b00};
    vt[10] = '{2'b01, 2'b01, 3'd4, 3'd0, 10'h007, 10'h000, 2'b01};
    vt[11] = '{2'b11, 2'b01, 3'd4, 3'd4, 10'h015, 10'h000, 2'b11};
    vt[12] = '{2'b00, 2'b00, 3'd0, 3'd0, 10'h000, 10'h000, 2'b00};
    vt[13] = '{2'b00, 2'b00, 3'd0, 3'd0, 10'h000, 10'h000, 2'b00};
    vt[14] = '{2'b01, 2'b00, 3'd6, 3'd0, 10'h000, 10'h000, 2'b01};
    vt[15] = '{2'b00, 2'b00, 3'd0, 3'd0, 10'h000, 10'h000, 2'b00};
    vt[16] = '{2'b00, 2'b00, 3'd0, 3'd0, 10'h000, 10'h000, 2'b00};

    @(posedge clk);
    #1;
    do_reset(2'b11, 2'b11);

    for (int i = 0; i < 17; i++) begin
      vcyc[i] = cyc;
      tick(vt[i].req, vt[i].we, {vt[i].a1, vt[i].a0}, {vt[i].d1, vt[i].d0}, g);
      chk("tbl_gnt", g, vt[i].gnt);
    end

    chk("wr_rd_valid", log_v[vcyc[7] + 2], 1);
    chk("wr_rd_id", log_id[vcyc[7] + 2], 1);
    chk("wr_rd_data", log_data[vcyc[7] + 2], 10'h02A);
`ifdef RAM_ARB_RAW_BYPASS_EN
    exp_raw = 10'h015;
`else
    exp_raw = 10'h007;
`endif
    chk("raw_rd_valid", log_v[vcyc[11] + 2], 1);
    chk("raw_rd_data", log_data[vcyc[11] + 2], exp_raw);
    chk("oor_rd_valid", log_v[vcyc[14] + 2], 1);
    chk("oor_rd_data", log_data[vcyc[14] + 2], 0);
    chk("oor_sticky", bus.addr_err, 1);

    for (int i = 0; i < 400; i++) begin
      tick(N_REQ'($urandom_range(0, 3)), N_REQ'($urandom_range(0, 3)),
           {ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7))},
           {DATA_W'($urandom), DATA_W'($urandom)}, g);
    end

    // Push both pointers to 1, then reset while a read is in flight.
    tick(2'b01, 2'b01, {3'd0, 3'd5}, {10'h000, 10'h155}, g);
    tick(2'b01, 2'b00, {3'd0, 3'd2}, {10'h000, 10'h000}, g);
    do_reset(2'b00, 2'b00);
    for (int i = 0; i < 4; i++) begin
      tick(2'b00, 2'b00, '0, '0, g);
    end
    tick(2'b11, 2'b11, {3'd2, 3'd1}, {10'h001, 10'h002}, g);
    chk("post_rst_wr_gnt", g, 2'b01);
    tick(2'b11, 2'b00, {3'd2, 3'd1}, '0, g);
    chk("post_rst_rd_gnt", g, 2'b01);
    for (int i = 0; i < 3; i++) begin
      tick(2'b00, 2'b00, '0, '0, g);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
